// File: rtl/keypad_scan.sv
// Keypad matrix scanner: walks one active-low row at a time, samples the active-low columns, debounces whole frames.
// Latency: press/release pulse lands 2 cycles after the deciding frame's last tick; no backpressure, pulses are fire-and-forget.
module keypad_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int CODE_W   = 4,
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [COLS-1:0]   col_in,
  output logic [ROWS-1:0]   row_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_down,
  output logic              key_release
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int STB_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

  logic [CNT_W-1:0]  cnt;
  logic [ROW_W-1:0]  row_idx;
  logic              tick;
  logic              row_hit;
  logic [COL_W-1:0]  hit_col;
  logic [CODE_W-1:0] row_code;
  logic              scr_vld;
  logic [CODE_W-1:0] scr_code;
  logic              merged_hit;
  logic [CODE_W-1:0] merged_code;
  logic              res_hit;
  logic [CODE_W-1:0] res_code;
  logic              eval;
  state_t            state;
  logic [CODE_W-1:0] cand;
  logic [STB_W-1:0]  stable;
  logic              stable_last;

  assign tick = (cnt == CNT_LAST);

  // Scanning downward leaves the lowest closed column as the winner.
  always_comb begin
    row_hit = 1'b0;
    hit_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_in[c]) begin
        row_hit = 1'b1;
        hit_col = COL_W'(c);
      end
    end
  end

  assign row_code    = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(hit_col);
  assign merged_hit  = scr_vld | row_hit;
  assign merged_code = scr_vld ? scr_code : row_code;
  assign stable_last = (int'(stable) + 1) >= DEBOUNCE;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      row_idx  <= '0;
      row_out  <= ~ROWS'(1);
      scr_vld  <= 1'b0;
      scr_code <= '0;
      res_hit  <= 1'b0;
      res_code <= '0;
      eval     <= 1'b0;
    end else begin
      eval <= 1'b0;
      if (tick) begin
        cnt <= '0;
        if (row_idx == ROW_LAST) begin
          row_idx  <= '0;
          row_out  <= ~ROWS'(1);
          res_hit  <= merged_hit;
          res_code <= merged_code;
          eval     <= 1'b1;
          scr_vld  <= 1'b0;
          scr_code <= '0;
        end else begin
          row_idx  <= row_idx + 1'b1;
          row_out  <= ~(ROWS'(1) << (row_idx + 1'b1));
          scr_vld  <= merged_hit;
          scr_code <= merged_code;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= '0;
      stable      <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_down    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (eval) begin
        case (state)
          IDLE: begin
            if (res_hit) begin
              if (DEBOUNCE <= 1) begin
                state     <= PRESSED;
                key_code  <= res_code;
                key_down  <= 1'b1;
                key_valid <= 1'b1;
              end else begin
                state  <= CAND;
                cand   <= res_code;
                stable <= STB_W'(1);
              end
            end
          end
          CAND: begin
            if (!res_hit) begin
              state <= IDLE;
            end else if (res_code != cand) begin
              cand   <= res_code;
              stable <= STB_W'(1);
            end else if (stable_last) begin
              state     <= PRESSED;
              key_code  <= cand;
              key_down  <= 1'b1;
              key_valid <= 1'b1;
            end else begin
              stable <= stable + 1'b1;
            end
          end
          PRESSED: begin
            // No rollover: any change, including a different key, starts release qualification.
            if (!res_hit && DEBOUNCE <= 1) begin
              state       <= IDLE;
              key_down    <= 1'b0;
              key_release <= 1'b1;
            end else if (!res_hit || res_code != key_code) begin
              state  <= REL;
              stable <= STB_W'(1);
            end
          end
          REL: begin
            if (!res_hit) begin
              if (stable_last) begin
                state       <= IDLE;
                key_down    <= 1'b0;
                key_release <= 1'b1;
              end else begin
                stable <= stable + 1'b1;
              end
            end else if (res_code == key_code) begin
              state <= PRESSED;
            end else begin
              stable <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart of the 8x16 LED matrix column driver: scans a passive switch matrix (keypad) instead of lighting one.
- Drives one active-low row at a time with the same dwell-and-advance row scan.
- Samples the active-low column lines at the end of each dwell, debounces over whole scan frames, and reports one key event per press and per release.
- Sits between the board keypad pins and the application logic that consumes key codes.

Parameters:
- ROWS, 4, number of driven rows (row_out width).
- COLS, 4, number of sensed columns (col_in width).
- CODE_W, 4, key_code width; must satisfy 2^CODE_W >= ROWS*COLS.
- SCAN_DIV, 5000, clock cycles each row is driven before sampling and advancing.
- DEBOUNCE, 3, consecutive identical frames required to accept a press or a release (>=1).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- col_in  in  COLS  column sense lines, active-low (pulled up externally; 0 = switch closed on driven row).
- row_out  out  ROWS  row drive, active-low one-hot.
- key_code  out  CODE_W  code of accepted key = row*COLS + col; holds last accepted value.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_down  out  1  level, high while an accepted key is considered held.
- key_release  out  1  one-cycle pulse when a release is accepted.

Behaviour:
- Reset (synchronous, active-high)
  - Values: row_out = ~1 (row 0 driven low), divider cnt = 0, row index = 0, FSM = IDLE, key_code = 0, key_valid = key_down = key_release = 0, frame scratch cleared.
  - Reset asserted mid-press or mid-debounce discards all progress; no pulses are emitted.
- Scan
  - cnt counts 0..SCAN_DIV-1; "tick" = cycle where cnt == SCAN_DIV-1.
  - On tick: sample col_in for the current row, wrap cnt to 0, advance the row index (ROWS-1 wraps to 0), and drive the new row from the next cycle.
  - Each row is driven exactly SCAN_DIV cycles; frame = ROWS*SCAN_DIV cycles.
- Frame result
  - A frame spans row 0 through ROWS-1.
  - The detected key is the lowest code with a 0 sample: lowest row first, then lowest column.
  - Multiple keys resolve to the lowest code. There is no ghost detection.
  - If no 0 sample is found, the result is NONE.
  - The result is registered on the tick of row ROWS-1. The FSM evaluates it on the following cycle (E).
- FSM (updates only on cycle E)
  - IDLE:
    - key k: go to CAND, cand = k, stable = 1. If DEBOUNCE = 1, accept immediately as in CAND.
    - NONE: stay.
  - CAND:
    - result == cand: stable+1. When stable reaches DEBOUNCE, go to PRESSED, key_code = cand, key_down = 1, key_valid = 1 for cycle E+1 only.
    - Different key: cand = new, stable = 1.
    - NONE: go to IDLE.
  - PRESSED:
    - result == key_code: stay.
    - NONE or any other key: go to REL, stable = 1. There is no rollover; a new key requires a release first.
  - REL:
    - NONE: stable+1. At DEBOUNCE, go to IDLE, key_down = 0, key_release = 1 for one cycle.
    - result == key_code: return to PRESSED (bounce); no pulse.
    - Other key: stable = 0, stay in REL.
- Pulse rules
  - key_valid and key_release are never high in the same cycle.
  - Each is high for exactly one cycle per event.
- Latency
  - Press accepted at the end of frame N+DEBOUNCE-1, where N is the first frame that sees the key.
  - key_valid rises 2 cycles after that frame's last tick (E, then register).
- key_code stays valid after release until the next accepted press.

Test Plan (SCAN_DIV=4, DEBOUNCE=3, ROWS=COLS=4; frame = 16 cycles):
- Reset, col_in=4'b1111 → row_out=1110 for cycles 0-3, 1101 for 4-7, 1011, 0111, then back to 1110 at cycle 16; outputs stay 0.
- Hold key 9 (col_in=4'b1101 whenever row_out=1011) for 3 full frames → exactly one key_valid pulse, key_code=9, key_down=1, held while key stays.
- Bounce sequence: key 9 present 2 frames, absent 1, present 3 → a single key_valid, after the final 3rd consecutive frame only.
- After 9 is accepted, release 2 frames, re-press → no key_release, no new key_valid. Then release 3 frames → one key_release, key_down=0, key_code still 9.
- Keys 2 and 13 held together for 3 frames → key_code=2. While pressed, release 2 and keep 13 held → FSM goes to REL, never emits key_valid for 13 until a full release (3 NONE frames) occurs.
- Assert reset for 1 cycle mid-debounce (CAND, stable=2) → next cycle row_out=1110, all outputs 0. A subsequent press needs 3 fresh frames.
